// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory subsystem: FSM states,
// MMIO register offsets and the address-region decoder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_t;

    localparam logic [3:0] MMIO_OFF_LED   = 4'h0;
    localparam logic [3:0] MMIO_OFF_CYCLE = 4'h4;

    // The MMIO window is 16-byte aligned, so matching the upper 28 bits is enough.
    function automatic region_t decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [27:0] mmio_page);
        if (addr < ram_bytes) begin
            return REG_RAM;
        end else if (addr[31:4] == mmio_page) begin
            return REG_MMIO;
        end else begin
            return REG_NONE;
        end
    endfunction

endpackage

// File: rtl/dmem_subsys_if.sv
// CPU data-port bus: request fields held stable by the master until ready,
// response fields valid while ready is high.
interface dmem_subsys_if;
    logic        req;
    logic        we;
    logic [3:0]  byte_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        fault;

    modport master (
        output req, we, byte_en, addr, wdata,
        input  rdata, ready, fault
    );

    modport slave (
        input  req, we, byte_en, addr, wdata,
        output rdata, ready, fault
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words split into four byte lanes,
// each with its own write enable; read data is registered.
module dmem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    byte_en,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (we && byte_en[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
                lane_q_reg <= lane_mem[addr];
            end

            assign rdata[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_subsys.sv
// Data-memory subsystem: request FSM with programmable wait states, RAM and
// MMIO decode, LED register and free-running cycle counter.
module dmem_subsys
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic          clk,
    input  logic          rst,
    dmem_subsys_if.slave  bus,
    output logic [7:0]    led_out,
    output logic [31:0]   cycle_cnt
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        accept;

    logic        we_reg;
    logic [3:0]  be_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic [31:0] rdata_reg, rdata_next;
    logic        fault_reg, fault_next;
    logic [7:0]  led_reg, led_next;
    logic [31:0] cycle_reg;

    region_t     region;
    logic [3:0]  mmio_off;
    logic        access_fault;
    logic        ram_we;
    logic        led_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_rdata;

    // State register, response registers, MMIO registers and counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            rdata_reg    <= 32'd0;
            fault_reg    <= 1'b0;
            led_reg      <= 8'd0;
            cycle_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            rdata_reg    <= rdata_next;
            fault_reg    <= fault_next;
            led_reg      <= led_next;
            cycle_reg    <= cycle_reg + 32'd1;
        end
    end

    // Request capture; only meaningful once accepted, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            we_reg    <= bus.we;
            be_reg    <= bus.byte_en;
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        accept        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    accept        = 1'b1;
                    wait_cnt_next = WAIT_INIT;
                    state_next    = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 4'd1;
                if (wait_cnt_reg <= 4'd1) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign region   = decode_region(addr_reg, RAM_BYTES, MMIO_BASE[31:4]);
    assign mmio_off = addr_reg[3:0];

    always_comb begin
        access_fault = 1'b0;
        if (addr_reg[1:0] != 2'b00 || region == REG_NONE) begin
            access_fault = 1'b1;
        end else if (region == REG_MMIO &&
                     mmio_off != MMIO_OFF_LED && mmio_off != MMIO_OFF_CYCLE) begin
            access_fault = 1'b1;
        end
    end

    // Gating with rst ensures a write caught by reset in ACCESS is dropped
    assign ram_we = rst && (state_reg == ST_ACCESS) && we_reg && !access_fault &&
                    (region == REG_RAM);
    assign led_we = (state_reg == ST_ACCESS) && we_reg && !access_fault &&
                    (region == REG_MMIO) && (mmio_off == MMIO_OFF_LED) && be_reg[0];

    // Present the incoming address while idle so the registered read is
    // already holding the latched word by the time ACCESS is reached.
    assign ram_addr = (state_reg == ST_IDLE) ? bus.addr[AW+1:2] : addr_reg[AW+1:2];

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .byte_en (be_reg),
        .addr    (ram_addr),
        .wdata   (wdata_reg),
        .rdata   (ram_rdata)
    );

    always_comb begin
        rdata_next = rdata_reg;
        fault_next = 1'b0;
        led_next   = led_reg;
        if (state_reg == ST_ACCESS) begin
            fault_next = access_fault;
            rdata_next = 32'd0;
            if (!access_fault && !we_reg) begin
                if (region == REG_RAM) begin
                    rdata_next = ram_rdata;
                end else if (mmio_off == MMIO_OFF_LED) begin
                    rdata_next = {24'd0, led_reg};
                end else begin
                    rdata_next = cycle_reg;
                end
            end
            if (led_we) begin
                led_next = wdata_reg[7:0];
            end
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.ready = (state_reg == ST_RESP);
    assign bus.fault = fault_reg;
    assign led_out   = led_reg;
    assign cycle_cnt = cycle_reg;

endmodule
